// File: rtl/fetch_pc_bpu_pkg.sv
// rtl/fetch_pc_bpu_pkg.sv - shared definitions for the fetch PC generator and branch predictor
// Purpose: reset PC default, sequential instruction length, BTB entry layout,
//          fetch FSM state encoding and the 2-bit saturating counter step.
// Ports:   none (package).
package fetch_pc_bpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          INST_LENTH       = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // Tag is stored at full word-address width (pc[31:2] >> IDX_W, zero-extended)
  // so the struct does not depend on the BTB depth.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/fetch_pc_bpu_if.sv
// rtl/fetch_pc_bpu_if.sv - fetch request and execute resolution bundle
// Purpose: groups the instruction fetch request port and the execute-stage
//          next-PC feedback into one interface.
// Ports:   master = fetch unit (drives if_valid/if_pc/if_pred_*/flush),
//          slave  = pipeline/memory side (drives if_ready and ex_*).
interface fetch_pc_bpu_if;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_dnpc;
  logic        ex_is_br;
  logic        ex_is_br_taken;
  logic [31:0] ex_pred_target;

  logic        flush;

  modport master (
    output if_valid, if_pc, if_pred_taken, if_pred_target, flush,
    input  if_ready, ex_valid, ex_pc, ex_dnpc, ex_is_br, ex_is_br_taken, ex_pred_target
  );

  modport slave (
    input  if_valid, if_pc, if_pred_taken, if_pred_target, flush,
    output if_ready, ex_valid, ex_pc, ex_dnpc, ex_is_br, ex_is_br_taken, ex_pred_target
  );

endinterface

// File: rtl/fetch_pc_bpu_btb.sv
// rtl/fetch_pc_bpu_btb.sv - direct-mapped BTB with 2-bit counters
// Purpose: storage array with a combinational lookup port, one write port that
//          either clears a valid bit (init walk) or applies a branch resolution.
// Ports:   clk; lookup_wpc in / lookup_hit, lookup_ctr, lookup_target out;
//          clear_en, clear_idx in; upd_en, upd_wpc, upd_taken, upd_target in.
module fetch_btb
  import fetch_pc_bpu_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic [29:0]      lookup_wpc,
  output logic             lookup_hit,
  output logic [1:0]       lookup_ctr,
  output logic [31:0]      lookup_target,
  input  logic             clear_en,
  input  logic [IDX_W-1:0] clear_idx,
  input  logic             upd_en,
  input  logic [29:0]      upd_wpc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target
);

  btb_entry_t mem [ENTRIES];

  logic [IDX_W-1:0] lu_idx;
  logic [IDX_W-1:0] up_idx;
  logic [29:0]      lu_tag;
  logic [29:0]      up_tag;
  btb_entry_t       lu_ent;
  btb_entry_t       up_ent;
  logic             up_hit;

  assign lu_idx = lookup_wpc[IDX_W-1:0];
  assign up_idx = upd_wpc[IDX_W-1:0];
  assign lu_tag = lookup_wpc >> IDX_W;
  assign up_tag = upd_wpc >> IDX_W;

  // Reads see the registered contents only: a same-cycle update is not bypassed.
  assign lu_ent = mem[lu_idx];
  assign up_ent = mem[up_idx];

  assign lookup_hit    = lu_ent.valid && (lu_ent.tag == lu_tag);
  assign lookup_ctr    = lu_ent.ctr;
  assign lookup_target = lu_ent.target;
  assign up_hit        = up_ent.valid && (up_ent.tag == up_tag);

  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem[clear_idx].valid <= 1'b0;
    end else if (upd_en) begin
      if (up_hit) begin
        mem[up_idx].ctr <= ctr_next(up_ent.ctr, upd_taken);
        if (upd_taken) begin
          mem[up_idx].target <= upd_target;
        end
      end else if (upd_taken) begin
        // Allocate weakly-taken, evicting whatever aliased here.
        mem[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: 2'b10};
      end
    end
  end

endmodule

// File: rtl/fetch_pc_bpu.sv
// rtl/fetch_pc_bpu.sv - fetch PC generator with BTB prediction and mispredict redirect
// Purpose: walks the BTB clear after reset (INIT), then issues fetch PCs,
//          follows the BTB prediction and redirects on any resolved next PC
//          that differs from the prediction recorded at fetch.
// Ports:   clk, rst_n (sync, active low); bus (fetch_pc_bpu_if.master);
//          perf_br_cnt, perf_mispred_cnt only when BPU_PERF_CNT_EN is defined.
module fetch_pc_bpu
  import fetch_pc_bpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          BTB_ENTRIES = 16,
  parameter int          INST_LEN    = INST_LENTH
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_pc_bpu_if.master bus
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]    perf_br_cnt,
  output logic [31:0]    perf_mispred_cnt
`endif
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  fetch_state_t     state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [31:0]      pc_q, pc_d;

  logic             run;
  logic             mispredict;
  logic             if_valid;
  logic             btb_hit;
  logic [1:0]       btb_ctr;
  logic [31:0]      btb_target;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             upd_en;

  // Byte offset of a resolving PC plays no part in BTB indexing or tagging.
  logic             unused_ex_pc_lsb;
  assign unused_ex_pc_lsb = ^bus.ex_pc[1:0];

  assign run         = (state_q == RUN);
  assign mispredict  = run && bus.ex_valid && (bus.ex_dnpc != bus.ex_pred_target);
  assign if_valid    = run && !mispredict;
  assign pred_taken  = btb_hit && btb_ctr[1];
  assign pred_target = pred_taken ? btb_target : pc_q + 32'(INST_LEN);
  // rst_n gate keeps a resolution arriving on the reset cycle out of the BTB.
  assign upd_en      = rst_n && run && bus.ex_valid && bus.ex_is_br;

  assign bus.if_valid       = if_valid;
  assign bus.if_pc          = pc_q;
  assign bus.if_pred_taken  = pred_taken;
  assign bus.if_pred_target = pred_target;
  assign bus.flush          = mispredict;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      pc_q       <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    pc_d       = pc_q;
    case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + IDX_W'(1);
        if (init_idx_q == IDX_W'(BTB_ENTRIES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Redirect wins over the normal advance.
        if (mispredict) begin
          pc_d = bus.ex_dnpc;
        end else if (if_valid && bus.if_ready) begin
          pc_d = pred_target;
        end
      end
      default: state_d = INIT;
    endcase
  end

  fetch_btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .lookup_wpc    (pc_q[31:2]),
    .lookup_hit    (btb_hit),
    .lookup_ctr    (btb_ctr),
    .lookup_target (btb_target),
    .clear_en      (!run),
    .clear_idx     (init_idx_q),
    .upd_en        (upd_en),
    .upd_wpc       (bus.ex_pc[31:2]),
    .upd_taken     (bus.ex_is_br_taken),
    .upd_target    (bus.ex_dnpc)
  );

`ifdef BPU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_br_cnt      <= '0;
      perf_mispred_cnt <= '0;
    end else begin
      if (run && bus.ex_valid && bus.ex_is_br) begin
        perf_br_cnt <= perf_br_cnt + 32'd1;
      end
      if (mispredict) begin
        perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_bpu.sv
// tb/tb_fetch_pc_bpu.sv - directed self-checking bench for fetch_pc_bpu
module tb_fetch_pc_bpu;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_pc_bpu_if bus ();

`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_mispred_cnt;
`endif
  int br_exp  = 0;
  int mis_exp = 0;

  fetch_pc_bpu #(
    .RESET_PC    (32'h8000_0000),
    .BTB_ENTRIES (16),
    .INST_LEN    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BPU_PERF_CNT_EN
    ,
    .perf_br_cnt      (perf_br_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // One-cycle resolution pulse; returns one cycle later with ex_valid dropped.
  task automatic resolve(input logic [31:0] pc, input logic [31:0] dnpc,
                         input logic is_br, input logic taken,
                         input logic [31:0] ptgt, input logic exp_flush);
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_dnpc        = dnpc;
    bus.ex_is_br       = is_br;
    bus.ex_is_br_taken = taken;
    bus.ex_pred_target = ptgt;
    #1;
    chk("flush", 32'(bus.flush), 32'(exp_flush));
    chk("if_valid_on_resolve", 32'(bus.if_valid), 32'(!exp_flush));
    if (exp_flush) mis_exp++;
    if (is_br) br_exp++;
    @(negedge clk);
    bus.ex_valid = 1'b0;
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    resolve(32'h8000_0F00, target, 1'b0, 1'b0, 32'h8000_0F04, 1'b1);
    chk("redirect_pc", bus.if_pc, target);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.if_ready       = 1'b1;
    bus.ex_valid       = 1'b0;
    bus.ex_pc          = '0;
    bus.ex_dnpc        = '0;
    bus.ex_is_br       = 1'b0;
    bus.ex_is_br_taken = 1'b0;
    bus.ex_pred_target = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_if_valid", 32'(bus.if_valid), 32'd0);
    chk("reset_flush", 32'(bus.flush), 32'd0);
    chk("reset_pc", bus.if_pc, 32'h8000_0000);

    // INIT walk: 16 cycles of no fetch after release
    rst_n = 1'b1;
    chk("init_valid", 32'(bus.if_valid), 32'd0);
    for (int i = 1; i < 16; i++) begin
      next_cycle();
      chk("init_valid", 32'(bus.if_valid), 32'd0);
    end
    next_cycle();
    chk("run_valid", 32'(bus.if_valid), 32'd1);
    chk("pc0", bus.if_pc, 32'h8000_0000);
    next_cycle();
    chk("pc1", bus.if_pc, 32'h8000_0004);
    next_cycle();
    chk("pc2", bus.if_pc, 32'h8000_0008);
    next_cycle();
    chk("pc3", bus.if_pc, 32'h8000_000C);

    // Taken branch mispredicted as fall-through: redirect and allocate
    resolve(32'h8000_0010, 32'h8000_0100, 1'b1, 1'b1, 32'h8000_0014, 1'b1);
    chk("mispred_pc", bus.if_pc, 32'h8000_0100);
    chk("cold_pred_taken", 32'(bus.if_pred_taken), 32'd0);
    chk("cold_pred_target", bus.if_pred_target, 32'h8000_0104);

    redirect(32'h8000_0010);
    chk("alloc_pred_taken", 32'(bus.if_pred_taken), 32'd1);
    chk("alloc_pred_target", bus.if_pred_target, 32'h8000_0100);
    next_cycle();
    chk("follow_pred", bus.if_pc, 32'h8000_0100);

    // ctr 10 -> 01
    resolve(32'h8000_0010, 32'h8000_0014, 1'b1, 1'b0, 32'h8000_0100, 1'b1);
    chk("nt_redirect_pc", bus.if_pc, 32'h8000_0014);
    redirect(32'h8000_0010);
    chk("ctr01_pred_taken", 32'(bus.if_pred_taken), 32'd0);
    chk("ctr01_pred_target", bus.if_pred_target, 32'h8000_0014);

    // 01 -> 00 -> 00 (low saturation), then taken twice -> 10
    resolve(32'h8000_0010, 32'h8000_0014, 1'b1, 1'b0, 32'h8000_0014, 1'b0);
    resolve(32'h8000_0010, 32'h8000_0014, 1'b1, 1'b0, 32'h8000_0014, 1'b0);
    resolve(32'h8000_0010, 32'h8000_0100, 1'b1, 1'b1, 32'h8000_0100, 1'b0);
    redirect(32'h8000_0010);
    chk("ctr_lo_step_pred", 32'(bus.if_pred_taken), 32'd0);
    resolve(32'h8000_0010, 32'h8000_0100, 1'b1, 1'b1, 32'h8000_0100, 1'b0);
    redirect(32'h8000_0010);
    chk("sat_lo_pred", 32'(bus.if_pred_taken), 32'd1);

    // 10 -> 11 -> 11 -> 11 (high saturation), not taken -> 10 still predicts taken
    repeat (3) resolve(32'h8000_0010, 32'h8000_0100, 1'b1, 1'b1, 32'h8000_0100, 1'b0);
    resolve(32'h8000_0010, 32'h8000_0014, 1'b1, 1'b0, 32'h8000_0100, 1'b1);
    redirect(32'h8000_0010);
    chk("sat_hi_pred", 32'(bus.if_pred_taken), 32'd1);

    // Wrong target on a hit: retarget
    resolve(32'h8000_0010, 32'h8000_0180, 1'b1, 1'b1, 32'h8000_0100, 1'b1);
    chk("retarget_pc", bus.if_pc, 32'h8000_0180);
    redirect(32'h8000_0010);
    chk("retarget_pred", bus.if_pred_target, 32'h8000_0180);

    // Stall holds pc; a mispredict during the stall still redirects
    bus.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("stall_pc", bus.if_pc, 32'h8000_0010);
      chk("stall_valid", 32'(bus.if_valid), 32'd1);
    end
    resolve(32'h8000_0030, 32'h8000_0040, 1'b0, 1'b0, 32'h8000_0034, 1'b1);
    chk("stall_redirect_pc", bus.if_pc, 32'h8000_0040);
    next_cycle();
    chk("stall_hold_after_redirect", bus.if_pc, 32'h8000_0040);
    bus.if_ready = 1'b1;

    // Trap: redirect without touching the BTB
    resolve(32'h8000_0020, 32'h8000_0200, 1'b0, 1'b0, 32'h8000_0024, 1'b1);
    chk("trap_pc", bus.if_pc, 32'h8000_0200);
    redirect(32'h8000_0020);
    chk("trap_no_alloc", 32'(bus.if_pred_taken), 32'd0);
    chk("trap_no_alloc_tgt", bus.if_pred_target, 32'h8000_0024);

    // Miss + not taken: no allocation
    resolve(32'h8000_0030, 32'h8000_0034, 1'b1, 1'b0, 32'h8000_0034, 1'b0);
    redirect(32'h8000_0030);
    chk("miss_nt_no_alloc", 32'(bus.if_pred_taken), 32'd0);

    // Same index as 0x10, different tag
    redirect(32'h8000_0050);
    chk("alias_pred_taken", 32'(bus.if_pred_taken), 32'd0);
    chk("alias_pred_target", bus.if_pred_target, 32'h8000_0054);

`ifdef BPU_PERF_CNT_EN
    chk("perf_br", perf_br_cnt, 32'(br_exp));
    chk("perf_mispred", perf_mispred_cnt, 32'(mis_exp));
`endif

    // Reset mid-run: INIT repeats and the BTB is wiped
    rst_n = 1'b0;
    br_exp  = 0;
    mis_exp = 0;
    next_cycle();
    chk("rerst_valid", 32'(bus.if_valid), 32'd0);
    chk("rerst_pc", bus.if_pc, 32'h8000_0000);
`ifdef BPU_PERF_CNT_EN
    chk("rerst_perf_br", perf_br_cnt, 32'd0);
    chk("rerst_perf_mispred", perf_mispred_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    // Resolution during INIT is ignored
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = 32'h8000_0010;
    bus.ex_dnpc        = 32'h8000_0300;
    bus.ex_is_br       = 1'b1;
    bus.ex_is_br_taken = 1'b1;
    bus.ex_pred_target = 32'h8000_0014;
    #1;
    chk("init_ex_no_flush", 32'(bus.flush), 32'd0);
    chk("reinit_valid", 32'(bus.if_valid), 32'd0);
    next_cycle();
    bus.ex_valid = 1'b0;
    for (int i = 2; i < 16; i++) begin
      next_cycle();
      chk("reinit_valid", 32'(bus.if_valid), 32'd0);
    end
    next_cycle();
    chk("rerun_valid", 32'(bus.if_valid), 32'd1);
    chk("rerun_pc", bus.if_pc, 32'h8000_0000);
`ifdef BPU_PERF_CNT_EN
    chk("rerun_perf_br", perf_br_cnt, 32'd0);
    chk("rerun_perf_mispred", perf_mispred_cnt, 32'd0);
`endif
    redirect(32'h8000_0010);
    chk("post_reset_pred_taken", 32'(bus.if_pred_taken), 32'd0);
    chk("post_reset_pred_target", bus.if_pred_target, 32'h8000_0014);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
